// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Flow per operation: IDLE (grant + latch operands/control) -> EXEC (one
// cycle for the shared ALU to settle, result captured at its end) -> RESP
// (result held for the granted requester until it takes it).
// Optional build macro: ALU_ARB_FIXED_PRIO_EN -- requester 0 always wins
// simultaneous requests; the default build uses round-robin arbitration.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic [1:0]       req0_ALU_op,
    input  logic [5:0]       req0_FuncCode,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic [1:0]       req1_ALU_op,
    input  logic [5:0]       req1_FuncCode,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_Output,
    output logic             rsp_Zero_Flag,
    output logic             rsp_Err,

    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [3:0]       ALU_Ctl,
    input  logic [WIDTH-1:0] alu_Output,
    input  logic             alu_Zero_Flag,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   gnt_id;     // requester owning the in-flight operation
    logic   err_q;      // illegal funct seen at acceptance
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic   last_grant; // winner of the most recent acceptance
`endif

    logic             any_valid;
    logic             pick;      // requester chosen this cycle (0/1)
    logic             accept;
    logic [WIDTH-1:0] sel_A;
    logic [WIDTH-1:0] sel_B;
    logic [1:0]       sel_op;
    logic [5:0]       sel_funct;
    logic [4:0]       sel_dec;   // {err, ctl}
    logic             rsp_take;

    // Main-control op plus R-type funct to 4-bit ALU control; {err, ctl}.
    function automatic logic [4:0] decode_ctl(input logic [1:0] op,
                                              input logic [5:0] funct);
        logic [4:0] d;
        d = 5'b0_0110;
        case (op)
            2'b00: d = 5'b0_0010;
            2'b01: d = 5'b0_0110;
            2'b11: d = 5'b0_0110;
            default: begin
                case (funct)
                    6'b100000: d = 5'b0_0010;
                    6'b100010: d = 5'b0_0110;
                    6'b100100: d = 5'b0_0000;
                    6'b100101: d = 5'b0_0001;
                    6'b101010: d = 5'b0_0111;
                    6'b100111: d = 5'b0_1100;
                    default:   d = 5'b1_1111;
                endcase
            end
        endcase
        return d;
    endfunction

    // Arbitration: pick a winner among the valid requesters.
    always_comb begin
        any_valid = req0_valid | req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
        pick = ~req0_valid;
`else
        if (req0_valid && req1_valid)
            pick = ~last_grant;
        else
            pick = ~req0_valid;
`endif
    end

    // Handshake is only possible in IDLE and never while reset is held.
    assign accept     = reset_n & (state == IDLE) & any_valid;
    assign req0_ready = accept & ~pick;
    assign req1_ready = accept &  pick;

    // Operand/control mux of the winning requester.
    always_comb begin
        sel_A     = pick ? req1_A        : req0_A;
        sel_B     = pick ? req1_B        : req0_B;
        sel_op    = pick ? req1_ALU_op   : req0_ALU_op;
        sel_funct = pick ? req1_FuncCode : req0_FuncCode;
        sel_dec   = decode_ctl(sel_op, sel_funct);
    end

    // Only the owner's response ready retires the operation.
    assign rsp_take = gnt_id ? rsp1_ready : rsp0_ready;

    // Controller FSM with registered outputs; ALU operands only move on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            gnt_id        <= 1'b0;
            err_q         <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant    <= 1'b1;
`endif
            alu_A         <= '0;
            alu_B         <= '0;
            ALU_Ctl       <= 4'b0000;
            rsp0_valid    <= 1'b0;
            rsp1_valid    <= 1'b0;
            rsp_Output    <= '0;
            rsp_Zero_Flag <= 1'b0;
            rsp_Err       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        alu_A   <= sel_A;
                        alu_B   <= sel_B;
                        ALU_Ctl <= sel_dec[3:0];
                        err_q   <= sel_dec[4];
                        gnt_id  <= pick;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant <= pick;
`endif
                        busy    <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_Output    <= alu_Output;
                    rsp_Zero_Flag <= alu_Zero_Flag;
                    rsp_Err       <= err_q;
                    rsp0_valid    <= ~gnt_id;
                    rsp1_valid    <=  gnt_id;
                    state         <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a driver issues operations and pushes
// the expected response; a monitor pops and checks whenever a response is
// presented, applying random backpressure. The bench also models the ALU.
module tb_alu_arbiter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic req0_valid = 0, req1_valid = 0;
    logic req0_ready, req1_ready;
    logic [W-1:0] req0_A = 0, req0_B = 0, req1_A = 0, req1_B = 0;
    logic [1:0] req0_ALU_op = 0, req1_ALU_op = 0;
    logic [5:0] req0_FuncCode = 0, req1_FuncCode = 0;
    logic rsp0_valid, rsp1_valid;
    logic rsp0_ready = 0, rsp1_ready = 0;
    logic [W-1:0] rsp_Output;
    logic rsp_Zero_Flag, rsp_Err;
    logic [W-1:0] alu_A, alu_B, alu_Output;
    logic [3:0] ALU_Ctl;
    logic alu_Zero_Flag, busy;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
        .req0_ALU_op(req0_ALU_op), .req0_FuncCode(req0_FuncCode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
        .req1_ALU_op(req1_ALU_op), .req1_FuncCode(req1_FuncCode),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_Output(rsp_Output), .rsp_Zero_Flag(rsp_Zero_Flag), .rsp_Err(rsp_Err),
        .alu_A(alu_A), .alu_B(alu_B), .ALU_Ctl(ALU_Ctl),
        .alu_Output(alu_Output), .alu_Zero_Flag(alu_Zero_Flag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared ALU behaviour.
    function automatic logic [W-1:0] alu_f(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        case (c)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return '0;
        endcase
    endfunction

    assign alu_Output    = alu_f(ALU_Ctl, alu_A, alu_B);
    assign alu_Zero_Flag = (alu_Output == '0);

    // Control table as written in the requirements; returns {err, ctl}.
    function automatic logic [4:0] spec_dec(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 5'b0_0010;
        if (op != 2'b10) return 5'b0_0110;
        case (f)
            6'b100000: return 5'b0_0010;
            6'b100010: return 5'b0_0110;
            6'b100100: return 5'b0_0000;
            6'b100101: return 5'b0_0001;
            6'b101010: return 5'b0_0111;
            6'b100111: return 5'b0_1100;
            default:   return 5'b1_1111;
        endcase
    endfunction

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   ctl;
        logic         zero;
        logic         err;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   next_stall = -1;
    logic mlast = 1'b1;   // model: last winner, round-robin
    logic [5:0] legal [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic set_req(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op, input logic [5:0] f);
        if (n == 0) begin
            req0_A = a; req0_B = b; req0_ALU_op = op; req0_FuncCode = f;
        end else begin
            req1_A = a; req1_B = b; req1_ALU_op = op; req1_FuncCode = f;
        end
    endtask

    task automatic rnd_req(input int n);
        logic [W-1:0] a, b;
        logic [5:0] f;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
        f = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : legal[$urandom_range(0, 5)];
        set_req(n, a, b, 2'($urandom_range(0, 3)), f);
    endtask

    // Present requesters in mask, wait for the predicted winner to be accepted.
    task automatic do_issue(input logic [1:0] mask, input int stall);
        exp_t e;
        logic w;
        logic [4:0] d;
        int t;
        @(negedge clk);
        req0_valid = mask[0];
        req1_valid = mask[1];
        if (mask == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            w = 1'b0;
`else
            w = ~mlast;
`endif
        end else begin
            w = mask[1];
        end
        e.id  = w;
        e.a   = w ? req1_A : req0_A;
        e.b   = w ? req1_B : req0_B;
        d     = w ? spec_dec(req1_ALU_op, req1_FuncCode) : spec_dec(req0_ALU_op, req0_FuncCode);
        e.ctl = d[3:0];
        e.err = d[4];
        e.res = alu_f(e.ctl, e.a, e.b);
        e.zero = (e.res == '0);
        #1;
        t = 0;
        while (!(w ? req1_ready : req0_ready) && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 40) begin
            fail("accept_timeout");
            req0_valid = 0;
            req1_valid = 0;
            return;
        end
        chk("loser_ready", {63'd0, (w ? req0_ready : req1_ready)}, 64'd0);
        e.acc = cyc + 1;
        sb.push_back(e);
        mlast = w;
        next_stall = stall;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0;
        req1_valid = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rsp_valid"}, {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
        chk({tag, "_req_ready"}, {62'd0, req1_ready, req0_ready}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_ALU_Ctl"}, {60'd0, ALU_Ctl}, 64'd0);
        chk({tag, "_alu_AB"}, {alu_A, alu_B}, 64'd0);
        chk({tag, "_rsp_bus"}, {30'd0, rsp_Zero_Flag, rsp_Err, rsp_Output}, 64'd0);
    endtask

    // Monitor: pop on first sight of a response, check it each cycle it is held.
    initial begin : mon
        exp_t cur;
        logic have;
        int st;
        have = 0;
        st = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                have = 0;
                rsp0_ready = 0;
                rsp1_ready = 0;
            end else if (rsp0_valid || rsp1_valid) begin
                if (!have) begin
                    if (sb.size() == 0) begin
                        fail("unexpected_rsp");
                    end else begin
                        cur = sb.pop_front();
                        have = 1;
                        chk("latency", 64'(cyc - cur.acc), 64'd1);
                        st = (next_stall >= 0) ? next_stall : int'($urandom_range(0, 3));
                        next_stall = -1;
                    end
                end
                if (have) begin
                    chk("rsp_id", {62'd0, rsp1_valid, rsp0_valid}, cur.id ? 64'd2 : 64'd1);
                    chk("rsp_Output", {32'd0, rsp_Output}, {32'd0, cur.res});
                    chk("rsp_Zero", {63'd0, rsp_Zero_Flag}, {63'd0, cur.zero});
                    chk("rsp_Err", {63'd0, rsp_Err}, {63'd0, cur.err});
                    chk("ALU_Ctl", {60'd0, ALU_Ctl}, {60'd0, cur.ctl});
                    chk("alu_AB", {alu_A, alu_B}, {cur.a, cur.b});
                    chk("busy_resp", {63'd0, busy}, 64'd1);
                    chk("req_ready_resp", {62'd0, req1_ready, req0_ready}, 64'd0);
                    if (st == 0) begin
                        rsp0_ready = ~cur.id;
                        rsp1_ready = cur.id;
                    end else begin
                        st--;
                        rsp0_ready = cur.id ? 1'($urandom_range(0, 1)) : 1'b0;
                        rsp1_ready = cur.id ? 1'b0 : 1'($urandom_range(0, 1));
                    end
                end
            end else begin
                have = 0;
                rsp0_ready = 0;
                rsp1_ready = 0;
            end
        end
    end

    initial begin : drv
        int t;
        // Reset state, with a request already waiting.
        req0_valid = 1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        req0_valid = 0;
        reset_n = 1;

        // Directed single-requester vectors.
        set_req(0, 32'h10696671, 32'h12345678, 2'b10, 6'b100000);
        do_issue(2'b01, 0);
        set_req(0, 32'h10696671, 32'h12345678, 2'b10, 6'b100010);
        do_issue(2'b01, 0);
        set_req(0, 32'h10696671, 32'h12345678, 2'b10, 6'b100100);
        do_issue(2'b01, 1);
        set_req(0, 32'h10696671, 32'h12345678, 2'b10, 6'b101010);
        do_issue(2'b01, 0);
        set_req(1, 32'h12345678, 32'h12345678, 2'b01, 6'b000000);
        do_issue(2'b10, 0);

        // Reset while the operation is in EXEC: dropped without a response.
        set_req(0, 32'hDEADBEEF, 32'h00000001, 2'b00, 6'b000000);
        do_issue(2'b01, 0);
        reset_n = 0;
        #1;
        chk_all_zero("midreset");
        if (sb.size() > 0) void'(sb.pop_back());
        mlast = 1'b1;
        next_stall = -1;
        @(negedge clk);
        reset_n = 1;

        // Contention: both valid for four operations.
        for (int i = 0; i < 4; i++) begin
            rnd_req(0);
            rnd_req(1);
            do_issue(2'b11, 0);
        end

        // Illegal funct held 5 cycles, requester 1 waiting meanwhile.
        set_req(0, 32'h10696671, 32'h12345678, 2'b10, 6'b111111);
        do_issue(2'b01, 5);
        rnd_req(1);
        do_issue(2'b10, 0);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            rnd_req(0);
            rnd_req(1);
            do_issue(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
        end

        t = 0;
        while ((sb.size() != 0 || rsp0_valid || rsp1_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) fail("drain_timeout");
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
